// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcodes, controller states and memory timeout shared by the CPU control logic
package pipe_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [7:0] WAIT_LIMIT = 8'd255;
  typedef enum logic [1:0] {S_RUN = 2'b00, S_MWAIT = 2'b01, S_HALT = 2'b10} state_t;
endpackage

// File: rtl/pipe_ctrl_ins_regs.sv
// ins_regs: decodes an instruction word into its destination and source register fields
module ins_regs
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic [4:0]  o_dest,
  output logic        o_dest_valid,
  output logic [4:0]  o_src1,
  output logic        o_src1_valid,
  output logic [4:0]  o_src2,
  output logic        o_src2_valid
);
  logic [5:0] w_op;
  logic       w_nop;
  logic       w_unused;
  assign w_op = i_ir[31:26];
  assign w_nop = i_ir == 32'd0;
  assign w_unused = ^i_ir[10:0];
  assign o_dest = (w_op == OP_RTYPE) ? i_ir[15:11] : i_ir[20:16];
  // r0 is hardwired, so writing it never produces a hazard
  assign o_dest_valid = !w_nop && o_dest != 5'd0 &&
    (w_op == OP_RTYPE || w_op == OP_ADDI || w_op == OP_ORI || w_op == OP_LW);
  assign o_src1 = i_ir[25:21];
  assign o_src1_valid = !w_nop && w_op != OP_J;
  assign o_src2 = i_ir[20:16];
  assign o_src2_valid = !w_nop && (w_op == OP_RTYPE || w_op == OP_SW || w_op == OP_BEQ);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard, branch-flush and memory-wait control for a 5-stage pipeline
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_ir,
  input  logic [31:0] ex_ir,
  input  logic [31:0] mem_ir,
  input  logic        ex_cond,
  input  logic        mem_ack,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        idex_we,
  output logic        exmem_we,
  output logic        memwb_we,
  output logic        ifid_clr,
  output logic        idex_clr,
  output logic        mem_req,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        mem_err
);
  state_t      r_state, w_next;
  logic [7:0]  r_wait;
  logic [7:0]  w_wait_inc;
  logic [15:0] r_stall, r_flush;
  logic        r_err;
  logic [4:0]  w_id_d, w_id_s1, w_id_s2, w_ex_d, w_ex_s1, w_ex_s2, w_mem_d, w_mem_s1, w_mem_s2;
  logic        w_id_dv, w_id_s1v, w_id_s2v, w_ex_dv, w_ex_s1v, w_ex_s2v, w_mem_dv, w_mem_s1v, w_mem_s2v;
  logic        w_taken, w_mem_ls, w_mem_busy, w_raw, w_freeze, w_flush, w_stall, w_unused;
  ins_regs u_id (.i_ir(id_ir), .o_dest(w_id_d), .o_dest_valid(w_id_dv), .o_src1(w_id_s1),
    .o_src1_valid(w_id_s1v), .o_src2(w_id_s2), .o_src2_valid(w_id_s2v));
  ins_regs u_ex (.i_ir(ex_ir), .o_dest(w_ex_d), .o_dest_valid(w_ex_dv), .o_src1(w_ex_s1),
    .o_src1_valid(w_ex_s1v), .o_src2(w_ex_s2), .o_src2_valid(w_ex_s2v));
  ins_regs u_mem (.i_ir(mem_ir), .o_dest(w_mem_d), .o_dest_valid(w_mem_dv), .o_src1(w_mem_s1),
    .o_src1_valid(w_mem_s1v), .o_src2(w_mem_s2), .o_src2_valid(w_mem_s2v));
  assign w_unused = ^{w_id_d, w_id_dv, w_ex_s1, w_ex_s1v, w_ex_s2, w_ex_s2v,
    w_mem_s1, w_mem_s1v, w_mem_s2, w_mem_s2v};
  assign w_taken = ex_ir[31:26] == OP_J || (ex_ir[31:26] == OP_BEQ && ex_cond);
  assign w_mem_ls = mem_ir[31:26] == OP_LW || mem_ir[31:26] == OP_SW;
  assign w_mem_busy = w_mem_ls && !mem_ack;
  assign w_wait_inc = r_wait + 8'd1;
  // WB-stage writers are ignored: the register file writes before it is read
  assign w_raw =
    (w_id_s1v && ((w_ex_dv && w_id_s1 == w_ex_d) || (w_mem_dv && w_id_s1 == w_mem_d))) ||
    (w_id_s2v && ((w_ex_dv && w_id_s2 == w_ex_d) || (w_mem_dv && w_id_s2 == w_mem_d)));
  // next state: a pending memory access parks the pipe in MWAIT until ack or timeout
  always_comb begin
    w_next = r_state;
    if (r_state == S_RUN) w_next = w_mem_busy ? S_MWAIT : S_RUN;
    else if (r_state == S_MWAIT) w_next = mem_ack ? S_RUN : (w_wait_inc == WAIT_LIMIT ? S_HALT : S_MWAIT);
  end
  // stage enables: freeze beats flush beats stall; a branch flush swallows the ID hazard
  always_comb begin
    w_freeze = r_state == S_HALT || w_mem_busy;
    w_flush = !w_freeze && w_taken;
    w_stall = !w_freeze && !w_taken && w_raw;
    pc_we = !w_freeze && !w_stall;
    ifid_we = !w_freeze && !w_stall;
    idex_we = !w_freeze;
    exmem_we = !w_freeze;
    memwb_we = !w_freeze;
    ifid_clr = w_flush;
    idex_clr = w_flush || w_stall;
    mem_req = w_mem_ls && r_state != S_HALT;
  end
  // state register on the stage-latching (falling) edge
  always_ff @(negedge clk or posedge rst)
    if (rst) r_state <= S_RUN;
    else r_state <= w_next;
  // wait timer, sticky timeout flag and saturating event counters
  always_ff @(negedge clk or posedge rst)
    if (rst) begin
      r_wait <= '0;
      r_err <= 1'b0;
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      r_wait <= r_state == S_RUN ? 8'd0 : (r_state == S_MWAIT ? w_wait_inc : r_wait);
      if (r_state == S_MWAIT && w_next == S_HALT) r_err <= 1'b1;
      if (w_stall && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
      if (w_flush && r_flush != 16'hFFFF) r_flush <= r_flush + 16'd1;
    end
  assign state = r_state;
  assign stall_cnt = r_stall;
  assign flush_cnt = r_flush;
  assign mem_err = r_err;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vector table plus multi-cycle sequences for pipe_ctrl
module tb_pipe_ctrl;
  localparam logic [5:0] RT = 6'h00, ADDI = 6'h08, ORI = 6'h0d, LW = 6'h23, SW = 6'h2b, BEQ = 6'h04;
  localparam logic [31:0] JMP = {6'h02, 26'h0200000};
  logic clk, rst, ex_cond, mem_ack;
  logic [31:0] id_ir, ex_ir, mem_ir;
  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_clr, idex_clr, mem_req, mem_err;
  logic [1:0] state;
  logic [15:0] stall_cnt, flush_cnt;
  logic [7:0] outs;
  int errors = 0, checks = 0;
  typedef struct {
    logic [31:0] id, ex, mem;
    logic cond, ack;
    logic [7:0] exp;
  } vec_t;
  vec_t v[15];
  pipe_ctrl dut (.clk(clk), .rst(rst), .id_ir(id_ir), .ex_ir(ex_ir), .mem_ir(mem_ir),
    .ex_cond(ex_cond), .mem_ack(mem_ack), .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
    .exmem_we(exmem_we), .memwb_we(memwb_we), .ifid_clr(ifid_clr), .idex_clr(idex_clr),
    .mem_req(mem_req), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err));
  assign outs = {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_clr, idex_clr, mem_req};
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd);
    return {RT, rs, rt, rd, 11'h020};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt);
    return {op, rs, rt, 16'h0004};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic set_in(input logic [31:0] id, ex, mem, input logic cond, ack);
    id_ir = id; ex_ir = ex; mem_ir = mem; ex_cond = cond; mem_ack = ack;
  endtask
  task automatic do_reset();
    set_in(0, 0, 0, 0, 1);
    rst = 1'b1;
    @(posedge clk);
    rst = 1'b0;
  endtask
  task automatic edge_n(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b0;
    set_in(0, 0, 0, 0, 1);
    v[0]  = '{0, 0, 0, 0, 1, 8'b11111000};
    v[1]  = '{r_ins(2, 4, 3), i_ins(LW, 1, 2), 0, 0, 1, 8'b00111010};
    v[2]  = '{0, i_ins(BEQ, 1, 2), 0, 1, 1, 8'b11111110};
    v[3]  = '{0, i_ins(BEQ, 1, 2), 0, 0, 1, 8'b11111000};
    v[4]  = '{0, JMP, 0, 0, 1, 8'b11111110};
    v[5]  = '{0, 0, i_ins(SW, 1, 2), 0, 1, 8'b11111001};
    v[6]  = '{0, 0, i_ins(SW, 1, 2), 0, 0, 8'b00000001};
    v[7]  = '{0, i_ins(BEQ, 1, 2), i_ins(LW, 1, 3), 1, 0, 8'b00000001};
    v[8]  = '{i_ins(SW, 5, 6), 0, i_ins(ADDI, 0, 5), 0, 1, 8'b00111010};
    v[9]  = '{r_ins(0, 0, 3), r_ins(1, 2, 0), 0, 0, 1, 8'b11111000};
    v[10] = '{i_ins(BEQ, 3, 7), i_ins(ORI, 1, 7), 0, 0, 1, 8'b00111010};
    v[11] = '{r_ins(2, 9, 3), i_ins(SW, 1, 2), 0, 0, 1, 8'b11111000};
    v[12] = '{JMP, i_ins(ADDI, 0, 1), 0, 0, 1, 8'b11111000};
    v[13] = '{r_ins(4, 9, 3), i_ins(BEQ, 1, 2), i_ins(ADDI, 0, 4), 1, 1, 8'b11111110};
    v[14] = '{i_ins(ADDI, 1, 5), i_ins(ADDI, 0, 5), 0, 0, 1, 8'b11111000};
    do_reset();
    #1;
    chk("reset_state", 32'(state), 0);
    chk("reset_stall", 32'(stall_cnt), 0);
    chk("reset_flush", 32'(flush_cnt), 0);
    chk("reset_err", 32'(mem_err), 0);
    for (int i = 0; i < 15; i++) begin
      do_reset();
      set_in(v[i].id, v[i].ex, v[i].mem, v[i].cond, v[i].ack);
      #1;
      chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(v[i].exp));
      chk($sformatf("vec%0d_state", i), 32'(state), 0);
    end
    do_reset();
    set_in(r_ins(2, 4, 3), i_ins(LW, 1, 2), 0, 0, 1);
    edge_n(1);
    chk("loaduse_stall_cnt", 32'(stall_cnt), 1);
    set_in(0, i_ins(BEQ, 1, 2), 0, 1, 1);
    edge_n(1);
    chk("branch_flush_cnt", 32'(flush_cnt), 1);
    set_in(r_ins(4, 9, 3), i_ins(BEQ, 1, 2), i_ins(ADDI, 0, 4), 1, 1);
    edge_n(1);
    chk("br_raw_flush_cnt", 32'(flush_cnt), 2);
    chk("br_raw_stall_cnt", 32'(stall_cnt), 1);
    set_in(r_ins(0, 0, 3), r_ins(1, 2, 0), 0, 0, 1);
    edge_n(1);
    chk("r0_stall_cnt", 32'(stall_cnt), 1);
    do_reset();
    set_in(0, 0, i_ins(SW, 1, 2), 0, 0);
    for (int c = 1; c <= 3; c++) begin
      edge_n(1);
      chk($sformatf("mwait%0d_state", c), 32'(state), 1);
      chk($sformatf("mwait%0d_outs", c), 32'(outs), 32'(8'b00000001));
    end
    @(posedge clk);
    mem_ack = 1'b1;
    #1;
    chk("ack_outs", 32'(outs), 32'(8'b11111001));
    edge_n(1);
    chk("ack_state", 32'(state), 0);
    do_reset();
    set_in(0, i_ins(BEQ, 1, 2), i_ins(LW, 1, 3), 1, 0);
    edge_n(1);
    chk("brbusy_state", 32'(state), 1);
    chk("brbusy_flush_cnt", 32'(flush_cnt), 0);
    @(posedge clk);
    mem_ack = 1'b1;
    #1;
    chk("brbusy_ack_outs", 32'(outs), 32'(8'b11111111));
    edge_n(1);
    chk("brbusy_ack_flush_cnt", 32'(flush_cnt), 1);
    chk("brbusy_ack_state", 32'(state), 0);
    do_reset();
    set_in(0, 0, i_ins(SW, 1, 2), 0, 0);
    edge_n(1);
    edge_n(254);
    chk("timeout_pre_state", 32'(state), 1);
    chk("timeout_pre_err", 32'(mem_err), 0);
    edge_n(1);
    chk("timeout_state", 32'(state), 2);
    chk("timeout_err", 32'(mem_err), 1);
    chk("timeout_outs", 32'(outs), 0);
    edge_n(5);
    chk("halt_sticky", 32'(state), 2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_err", 32'(mem_err), 0);
    mem_ir = 0;
    @(posedge clk);
    rst = 1'b0;
    do_reset();
    set_in(r_ins(2, 4, 3), i_ins(LW, 1, 2), 0, 0, 1);
    edge_n(65535);
    chk("sat_reach", 32'(stall_cnt), 32'hFFFF);
    edge_n(3);
    chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: pipeline clock. State and counters update on the falling edge, the same edge on which the stage registers latch.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port id_ir, input, 32 bits: instruction currently held in the ID stage.
REQ-004 SHALL have ports ex_ir and mem_ir, input, 32 bits each: instructions held in the EX and MEM stages.
REQ-005 SHALL have port ex_cond, input, 1 bit: branch condition computed in EX.
REQ-006 SHALL have port mem_ack, input, 1 bit: data memory completes the current access this cycle.
REQ-007 SHALL have ports pc_we, ifid_we, idex_we, exmem_we and memwb_we, output, 1 bit each: stage-register load enables.
REQ-008 SHALL have ports ifid_clr and idex_clr, output, 1 bit each: load all-zero (NOP) into the stage register; clr overrides we.
REQ-009 SHALL have port mem_req, output, 1 bit: data-memory access request.
REQ-010 SHALL have port state, output, 2 bits: 00 RUN, 01 MWAIT, 10 HALT.
REQ-011 SHALL have ports stall_cnt and flush_cnt, output, 16 bits each: saturating event counters.
REQ-012 SHALL have port mem_err, output, 1 bit: sticky memory-timeout flag.

Function
REQ-013 SHALL decode each instruction as follows.
- Destination: rd = IR[15:11] for R-type (opcode 000000); rt = IR[20:16] for ADDI, ORI and LW; none for SW, BEQ and J.
- Destination r0 never creates a hazard.
REQ-014 SHALL decode ID sources as follows.
- rs for all instructions except J.
- rt additionally for R-type, SW and BEQ.
REQ-015 SHALL flag a RAW hazard when an ID source equals a valid destination of ex_ir or mem_ir. A WB-stage match is not a hazard, because register-file write precedes read.
REQ-016 SHALL define a taken branch as: ex_ir is J, or ex_ir is BEQ with ex_cond=1.
REQ-017 SHALL define mem_busy as: mem_ir is LW or SW, and mem_ack=0.
REQ-018 SHALL assert mem_req combinationally whenever mem_ir is LW or SW and state is RUN or MWAIT.
REQ-019 SHALL apply the following priority, all outputs combinational from state and inputs.
- (1) HALT or mem_busy: all we=0, all clr=0.
- (2) Taken branch: all we=1, ifid_clr=1, idex_clr=1.
- (3) RAW: pc_we=0, ifid_we=0, idex_clr=1, exmem_we=1, memwb_we=1.
- (4) Otherwise: all we=1, all clr=0.
REQ-020 SHALL implement the following state transitions.
- RUN->MWAIT on a falling edge where mem_busy=1.
- MWAIT->RUN on a falling edge where mem_ack=1.
- MWAIT->HALT when the wait counter reaches 255 without mem_ack.
- HALT is left only by rst.
REQ-021 SHALL implement the wait counter as 8 bits: clear in RUN, increment on each falling edge in MWAIT.
REQ-022 SHALL set mem_err=1 on entry to HALT and hold it until rst.
REQ-023 SHALL increment stall_cnt once per cycle in which priority (3) is applied.
REQ-024 SHALL increment flush_cnt once per cycle in which priority (2) is applied.
REQ-025 SHALL saturate both counters at 0xFFFF with no wrap-around.
REQ-026 SHALL resolve a taken branch coinciding with mem_busy as priority (1): the branch is held in EX and re-evaluated on the cycle mem_ack arrives.
REQ-027 SHALL resolve a taken branch coinciding with RAW as priority (2): the ID instruction is flushed and no stall is counted.
REQ-028 SHALL treat an all-zero IR as a NOP with no destination and no sources.

Reset
REQ-029 SHALL, on rst=1, immediately force the following, independent of clk.
- state=RUN, wait counter=0, stall_cnt=0, flush_cnt=0, mem_err=0.
REQ-030 SHALL abandon an in-progress MWAIT or HALT on a reset asserted mid-operation; the controller returns to RUN with outputs recomputed from current inputs.

Structure
REQ-031 SHALL place opcode constants (RTYPE, ADDI, ORI, LW, SW, BEQ, J), state encodings and the 255 timeout limit in the shared CPU package.
REQ-032 SHALL use one sub-module, ins_regs: a combinational decode of IR into dest[4:0], dest_valid, src1/src2 and their valid bits, instantiated three times (ID, EX, MEM).

Verification
REQ-033 SHALL cover load-use hazard.
- Stimulus: ex_ir=LW r2,0(r1); id_ir=ADD r3,r2,r4.
- Required: pc_we=0, ifid_we=0, idex_clr=1; stall_cnt goes 0->1.
REQ-034 SHALL cover a taken branch.
- Stimulus: ex_ir=BEQ, ex_cond=1.
- Required: ifid_clr=1, idex_clr=1, pc_we=1; flush_cnt=1.
- With ex_cond=0, no clr is asserted.
REQ-035 SHALL cover a memory wait.
- Stimulus: mem_ir=SW, mem_ack low for 3 cycles.
- Required: state=01, all we=0 for 3 cycles, mem_req=1; on ack, state=00.
REQ-036 SHALL cover the memory timeout.
- Stimulus: mem_ack never asserted.
- Required: HALT after 255 MWAIT cycles, mem_err=1, all we=0; rst returns state=00 and mem_err=0.
REQ-037 SHALL cover simultaneous events.
- Taken BEQ plus RAW: flush applied and stall_cnt unchanged.
- Taken BEQ plus mem_busy: freeze, then flush on the ack cycle.
REQ-038 SHALL cover r0 and saturation.
- ADD r0,... in EX followed by a reader of r0 gives no stall.
- stall_cnt preset to 0xFFFF by forcing 65535 stalls stays at 0xFFFF.
